// File: rtl/dram_dma_arb_pkg.sv
// Shared types for the DRAM DMA arbiter: packet layout, arbitration FSM states
// and the requester-id width helper.
package dram_dma_arb_pkg;

    localparam int unsigned dma_caddr_width_c = 28;

    typedef struct packed {
        logic                         write_not_read;
        logic [dma_caddr_width_c-1:0] addr;
    } dma_pkt_s;

    typedef enum logic {
        e_idle = 1'b0,
        e_lock = 1'b1
    } arb_fsm_e;

    // Requester ids need at least one bit even when only one requester exists.
    function automatic int unsigned req_id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/dram_dma_id_fifo.sv
// Small in-order FIFO of requester ids with a registered occupancy count.
// A push while full is dropped; callers gate pushes on full_o.
module dram_dma_id_fifo #(
    parameter int unsigned width_p = 1,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

    logic [width_p-1:0]  mem_q [els_p];
    logic [width_p-1:0]  mem_d [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                push_ok, pop_ok;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] ptr);
        return (ptr == last_ptr_lp) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == full_cnt_lp);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + cnt_w_lp'(push_ok) - cnt_w_lp'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dram_dma_arbiter.sv
// Round-robin arbiter sharing one DMA port (pkt/rdata/wdata) among requesters.
// Optional DRAM_DMA_ARB_STATS_EN adds packet and stall counters.
module dram_dma_arbiter
    import dram_dma_arb_pkg::*;
#(
    parameter int unsigned num_req_p         = 2,
    parameter int unsigned caddr_width_p     = 28,
    parameter int unsigned fill_width_p      = 64,
    parameter int unsigned burst_len_p       = 8,
    parameter int unsigned max_outstanding_p = 4
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,

    input  logic [num_req_p*(caddr_width_p+1)-1:0]  req_pkt_i,
    input  logic [num_req_p-1:0]                    req_pkt_v_i,
    output logic [num_req_p-1:0]                    req_pkt_yumi_o,

    output logic [fill_width_p-1:0]                 req_rdata_o,
    output logic [num_req_p-1:0]                    req_rdata_v_o,
    input  logic [num_req_p-1:0]                    req_rdata_ready_and_i,

    input  logic [num_req_p*fill_width_p-1:0]       req_wdata_i,
    input  logic [num_req_p-1:0]                    req_wdata_v_i,
    output logic [num_req_p-1:0]                    req_wdata_yumi_o,

    output logic [caddr_width_p:0]                  dma_pkt_o,
    output logic                                    dma_pkt_v_o,
    input  logic                                    dma_pkt_yumi_i,

    input  logic [fill_width_p-1:0]                 dma_data_i,
    input  logic                                    dma_data_v_i,
    output logic                                    dma_data_ready_and_o,

    output logic [fill_width_p-1:0]                 dma_data_o,
    output logic                                    dma_data_v_o,
    input  logic                                    dma_data_yumi_i,

`ifdef DRAM_DMA_ARB_STATS_EN
    output logic [num_req_p*32-1:0]                 stats_o,
    output logic [31:0]                             stall_cnt_o,
`endif
    output logic                                    dbg_state_o
);

    // Handshakes: a transfer happens in a cycle where valid and yumi (or valid
    // and ready_and) are both high; valid never waits on yumi/ready.

    localparam int unsigned pkt_w_lp  = caddr_width_p + 1;
    localparam int unsigned id_w_lp   = req_id_width(num_req_p);
    localparam int unsigned beat_w_lp = $clog2(burst_len_p);
    localparam logic [id_w_lp-1:0]   last_id_lp   = id_w_lp'(num_req_p - 1);
    localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(burst_len_p - 1);

    arb_fsm_e             state_q, state_d;
    logic [id_w_lp-1:0]   grant_q, grant_d;
    logic [id_w_lp-1:0]   rr_q, rr_d;
    logic [id_w_lp-1:0]   pick, sel;
    logic                 any_elig;
    logic [num_req_p-1:0] elig;
    logic                 pkt_fire, pkt_wnr;

    logic                 rfifo_push, rfifo_pop, rfull, rempty;
    logic                 wfifo_push, wfifo_pop, wfull, wempty;
    logic [id_w_lp-1:0]   rhead, whead;
    logic [beat_w_lp-1:0] rbeat_q, rbeat_d, wbeat_q, wbeat_d;
    logic                 rfire, wfire;

    function automatic logic [id_w_lp-1:0] next_id(input logic [id_w_lp-1:0] id);
        return (id == last_id_lp) ? '0 : id + 1'b1;
    endfunction

    // Full flags are registered, so a same-cycle pop never makes room for a grant.
    always_comb begin
        elig = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (req_pkt_i[i*pkt_w_lp + caddr_width_p])
                elig[i] = req_pkt_v_i[i] & ~wfull & ~reset_i;
            else
                elig[i] = req_pkt_v_i[i] & ~rfull & ~reset_i;
        end
    end

    always_comb begin
        pick     = '0;
        any_elig = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!any_elig && elig[i] && (i >= int'(rr_q))) begin
                any_elig = 1'b1;
                pick     = id_w_lp'(i);
            end
        end
        for (int i = 0; i < num_req_p; i++) begin
            if (!any_elig && elig[i]) begin
                any_elig = 1'b1;
                pick     = id_w_lp'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (state_q == e_idle) begin
            if (any_elig) begin
                if (dma_pkt_yumi_i) begin
                    rr_d = next_id(pick);
                end else begin
                    state_d = e_lock;
                    grant_d = pick;
                end
            end
        end else begin
            if (dma_pkt_yumi_i) begin
                state_d = e_idle;
                rr_d    = next_id(grant_q);
            end
        end
    end

    always_comb begin
        req_pkt_yumi_o = '0;
        if (state_q == e_idle) begin
            sel         = pick;
            dma_pkt_v_o = any_elig;
        end else begin
            sel         = grant_q;
            dma_pkt_v_o = 1'b1;
        end
        dma_pkt_o  = req_pkt_i[int'(sel)*pkt_w_lp +: pkt_w_lp];
        pkt_wnr    = dma_pkt_o[caddr_width_p];
        pkt_fire   = dma_pkt_v_o & dma_pkt_yumi_i;
        rfifo_push = pkt_fire & ~pkt_wnr;
        wfifo_push = pkt_fire & pkt_wnr;
        if (pkt_fire) req_pkt_yumi_o[sel] = 1'b1;
    end

    assign dbg_state_o = state_q;

    dram_dma_id_fifo #(.width_p(id_w_lp), .els_p(max_outstanding_p)) rd_id_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (rfifo_push),
        .data_i  (sel),
        .pop_i   (rfifo_pop),
        .data_o  (rhead),
        .full_o  (rfull),
        .empty_o (rempty)
    );

    dram_dma_id_fifo #(.width_p(id_w_lp), .els_p(max_outstanding_p)) wr_id_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (wfifo_push),
        .data_i  (sel),
        .pop_i   (wfifo_pop),
        .data_o  (whead),
        .full_o  (wfull),
        .empty_o (wempty)
    );

    assign req_rdata_o = dma_data_i;

    // Read bursts return in packet order; the read FIFO head owns every beat.
    always_comb begin
        req_rdata_v_o        = '0;
        dma_data_ready_and_o = ~rempty & req_rdata_ready_and_i[rhead];
        if (!rempty) req_rdata_v_o[rhead] = dma_data_v_i;
        rfire     = dma_data_v_i & dma_data_ready_and_o;
        rbeat_d   = rbeat_q;
        rfifo_pop = 1'b0;
        if (rfire) begin
            if (rbeat_q == last_beat_lp) begin
                rbeat_d   = '0;
                rfifo_pop = 1'b1;
            end else begin
                rbeat_d = rbeat_q + 1'b1;
            end
        end
    end

    always_comb begin
        req_wdata_yumi_o = '0;
        dma_data_v_o     = ~wempty & req_wdata_v_i[whead];
        dma_data_o       = req_wdata_i[int'(whead)*fill_width_p +: fill_width_p];
        wfire            = dma_data_v_o & dma_data_yumi_i;
        if (wfire) req_wdata_yumi_o[whead] = 1'b1;
        wbeat_d   = wbeat_q;
        wfifo_pop = 1'b0;
        if (wfire) begin
            if (wbeat_q == last_beat_lp) begin
                wbeat_d   = '0;
                wfifo_pop = 1'b1;
            end else begin
                wbeat_d = wbeat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rbeat_q <= '0;
            wbeat_q <= '0;
        end else begin
            rbeat_q <= rbeat_d;
            wbeat_q <= wbeat_d;
        end
    end

`ifdef DRAM_DMA_ARB_STATS_EN
    logic [num_req_p*32-1:0] stats_q, stats_d;
    logic [31:0]             stall_q, stall_d;

    always_comb begin
        stats_d = stats_q;
        stall_d = stall_q;
        for (int i = 0; i < num_req_p; i++) begin
            if (req_pkt_yumi_o[i] && (stats_q[i*32 +: 32] != 32'hFFFF_FFFF))
                stats_d[i*32 +: 32] = stats_q[i*32 +: 32] + 32'd1;
        end
        if (dma_pkt_v_o && !dma_pkt_yumi_i && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stats_q <= '0;
            stall_q <= '0;
        end else begin
            stats_q <= stats_d;
            stall_q <= stall_d;
        end
    end

    assign stats_o     = stats_q;
    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_dram_dma_arbiter.sv
// Directed bench for dram_dma_arbiter: reset, read return, round robin, lock,
// write steering, FIFO full back-pressure and mid-burst reset.
module tb_dram_dma_arbiter;

    localparam int N  = 2;
    localparam int CA = 28;
    localparam int PW = CA + 1;
    localparam int FW = 64;
    localparam int BL = 8;
    localparam int MO = 4;

    logic              clk;
    logic              reset_i;
    logic [N*PW-1:0]   req_pkt_i;
    logic [N-1:0]      req_pkt_v_i;
    logic [N-1:0]      req_pkt_yumi_o;
    logic [FW-1:0]     req_rdata_o;
    logic [N-1:0]      req_rdata_v_o;
    logic [N-1:0]      req_rdata_ready_and_i;
    logic [N*FW-1:0]   req_wdata_i;
    logic [N-1:0]      req_wdata_v_i;
    logic [N-1:0]      req_wdata_yumi_o;
    logic [PW-1:0]     dma_pkt_o;
    logic              dma_pkt_v_o;
    logic              dma_pkt_yumi_i;
    logic [FW-1:0]     dma_data_i;
    logic              dma_data_v_i;
    logic              dma_data_ready_and_o;
    logic [FW-1:0]     dma_data_o;
    logic              dma_data_v_o;
    logic              dma_data_yumi_i;
    logic              dbg_state_o;
`ifdef DRAM_DMA_ARB_STATS_EN
    logic [N*32-1:0]   stats_o;
    logic [31:0]       stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    dram_dma_arbiter #(
        .num_req_p(N), .caddr_width_p(CA), .fill_width_p(FW),
        .burst_len_p(BL), .max_outstanding_p(MO)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .req_pkt_i             (req_pkt_i),
        .req_pkt_v_i           (req_pkt_v_i),
        .req_pkt_yumi_o        (req_pkt_yumi_o),
        .req_rdata_o           (req_rdata_o),
        .req_rdata_v_o         (req_rdata_v_o),
        .req_rdata_ready_and_i (req_rdata_ready_and_i),
        .req_wdata_i           (req_wdata_i),
        .req_wdata_v_i         (req_wdata_v_i),
        .req_wdata_yumi_o      (req_wdata_yumi_o),
        .dma_pkt_o             (dma_pkt_o),
        .dma_pkt_v_o           (dma_pkt_v_o),
        .dma_pkt_yumi_i        (dma_pkt_yumi_i),
        .dma_data_i            (dma_data_i),
        .dma_data_v_i          (dma_data_v_i),
        .dma_data_ready_and_o  (dma_data_ready_and_o),
        .dma_data_o            (dma_data_o),
        .dma_data_v_o          (dma_data_v_o),
        .dma_data_yumi_i       (dma_data_yumi_i),
`ifdef DRAM_DMA_ARB_STATS_EN
        .stats_o               (stats_o),
        .stall_cnt_o           (stall_cnt_o),
`endif
        .dbg_state_o           (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_pkt_i             = '0;
        req_pkt_v_i           = '0;
        req_rdata_ready_and_i = '0;
        req_wdata_i           = '0;
        req_wdata_v_i         = '0;
        dma_pkt_yumi_i        = 1'b0;
        dma_data_i            = '0;
        dma_data_v_i          = 1'b0;
        dma_data_yumi_i       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_pkt(input int r, input logic wnr, input logic [CA-1:0] addr);
        req_pkt_i[r*PW +: PW] = {wnr, addr};
    endtask

    task automatic set_wdata(input int r, input logic [FW-1:0] d);
        req_wdata_i[r*FW +: FW] = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        #1;
        total++; if (dma_pkt_v_o !== 1'b0) begin bad++; $display("FAIL rst_pkt_v got=%0b exp=0", dma_pkt_v_o); end
        total++; if (req_pkt_yumi_o !== 2'b00) begin bad++; $display("FAIL rst_pkt_yumi got=%b exp=00", req_pkt_yumi_o); end
        total++; if (req_rdata_v_o !== 2'b00) begin bad++; $display("FAIL rst_rdata_v got=%b exp=00", req_rdata_v_o); end
        total++; if (dma_data_ready_and_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", dma_data_ready_and_o); end
        total++; if (dma_data_v_o !== 1'b0) begin bad++; $display("FAIL rst_wdata_v got=%0b exp=0", dma_data_v_o); end
        total++; if (req_wdata_yumi_o !== 2'b00) begin bad++; $display("FAIL rst_wyumi got=%b exp=00", req_wdata_yumi_o); end
        total++; if (dbg_state_o !== 1'b0) begin bad++; $display("FAIL rst_state got=%0b exp=0", dbg_state_o); end
        reset_i = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_pkt(0, 1'b0, 28'h100);
        req_pkt_v_i    = 2'b01;
        dma_pkt_yumi_i = 1'b1;
        #1;
        total++; if (dma_pkt_v_o !== 1'b1) begin bad++; $display("FAIL rd_pkt_v got=%0b exp=1", dma_pkt_v_o); end
        total++; if (dma_pkt_o !== 29'h100) begin bad++; $display("FAIL rd_pkt got=%h exp=100", dma_pkt_o); end
        total++; if (req_pkt_yumi_o !== 2'b01) begin bad++; $display("FAIL rd_pkt_yumi got=%b exp=01", req_pkt_yumi_o); end
        tick();
        req_pkt_v_i           = 2'b00;
        dma_pkt_yumi_i        = 1'b0;
        req_rdata_ready_and_i = 2'b11;
        dma_data_v_i          = 1'b1;
        for (int b = 0; b < BL; b++) begin
            dma_data_i = 64'hA0 + 64'(b);
            #1;
            total++; if (req_rdata_v_o !== 2'b01) begin bad++; $display("FAIL rd_beat%0d_v got=%b exp=01", b, req_rdata_v_o); end
            total++; if (req_rdata_o !== 64'hA0 + 64'(b)) begin bad++; $display("FAIL rd_beat%0d_data got=%h exp=%h", b, req_rdata_o, 64'hA0 + 64'(b)); end
            total++; if (dma_data_ready_and_o !== 1'b1) begin bad++; $display("FAIL rd_beat%0d_ready got=%0b exp=1", b, dma_data_ready_and_o); end
            tick();
        end
        dma_data_i = 64'hA8;
        #1;
        total++; if (dma_data_ready_and_o !== 1'b0) begin bad++; $display("FAIL rd_stray_ready got=%0b exp=0", dma_data_ready_and_o); end
        total++; if (req_rdata_v_o !== 2'b00) begin bad++; $display("FAIL rd_stray_v got=%b exp=00", req_rdata_v_o); end
        dma_data_v_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_yumi [3];
        logic [PW-1:0] exp_pkt [3];
        exp_yumi[0] = 2'b10; exp_pkt[0] = 29'h300;
        exp_yumi[1] = 2'b01; exp_pkt[1] = 29'h200;
        exp_yumi[2] = 2'b10; exp_pkt[2] = 29'h300;
        do_reset();
        set_pkt(0, 1'b0, 28'h200);
        set_pkt(1, 1'b0, 28'h300);
        req_pkt_v_i    = 2'b11;
        dma_pkt_yumi_i = 1'b0;
        #1;
        total++; if (dma_pkt_o !== 29'h200 || req_pkt_yumi_o !== 2'b00) begin bad++; $display("FAIL rr_first got=%h/%b exp=200/00", dma_pkt_o, req_pkt_yumi_o); end
        tick();
        dma_pkt_yumi_i = 1'b1;
        #1;
        total++; if (dma_pkt_o !== 29'h200 || req_pkt_yumi_o !== 2'b01) begin bad++; $display("FAIL rr_g0 got=%h/%b exp=200/01", dma_pkt_o, req_pkt_yumi_o); end
        tick();
        for (int g = 0; g < 3; g++) begin
            #1;
            total++; if (dma_pkt_o !== exp_pkt[g] || req_pkt_yumi_o !== exp_yumi[g]) begin bad++; $display("FAIL rr_g%0d got=%h/%b exp=%h/%b", g + 1, dma_pkt_o, req_pkt_yumi_o, exp_pkt[g], exp_yumi[g]); end
            tick();
        end
        #1;
        total++; if (dma_pkt_v_o !== 1'b0) begin bad++; $display("FAIL rr_full_v got=%0b exp=0", dma_pkt_v_o); end
        clear_inputs();
    endtask

    task automatic test_lock_hold();
        do_reset();
        set_pkt(0, 1'b0, 28'h400);
        req_pkt_v_i    = 2'b01;
        dma_pkt_yumi_i = 1'b0;
        tick();
        set_pkt(1, 1'b0, 28'h500);
        req_pkt_v_i = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (dma_pkt_v_o !== 1'b1 || dma_pkt_o !== 29'h400) begin bad++; $display("FAIL lock_c%0d_pkt got=%0b/%h exp=1/400", c, dma_pkt_v_o, dma_pkt_o); end
            total++; if (req_pkt_yumi_o !== 2'b00 || dbg_state_o !== 1'b1) begin bad++; $display("FAIL lock_c%0d_state got=%b/%0b exp=00/1", c, req_pkt_yumi_o, dbg_state_o); end
            tick();
        end
        dma_pkt_yumi_i = 1'b1;
        #1;
        total++; if (req_pkt_yumi_o !== 2'b01 || dma_pkt_o !== 29'h400) begin bad++; $display("FAIL lock_release got=%b/%h exp=01/400", req_pkt_yumi_o, dma_pkt_o); end
        tick();
        req_pkt_v_i = 2'b10;
        #1;
        total++; if (req_pkt_yumi_o !== 2'b10 || dma_pkt_o !== 29'h500) begin bad++; $display("FAIL lock_next got=%b/%h exp=10/500", req_pkt_yumi_o, dma_pkt_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_write_steer();
        do_reset();
        set_pkt(1, 1'b1, 28'h600);
        req_pkt_v_i     = 2'b10;
        dma_pkt_yumi_i  = 1'b1;
        set_wdata(1, 64'hB0);
        req_wdata_v_i   = 2'b10;
        #1;
        total++; if (req_pkt_yumi_o !== 2'b10 || dma_pkt_o !== 29'h1000_0600) begin bad++; $display("FAIL wr_pkt got=%b/%h exp=10/10000600", req_pkt_yumi_o, dma_pkt_o); end
        total++; if (dma_data_v_o !== 1'b0) begin bad++; $display("FAIL wr_early_v got=%0b exp=0", dma_data_v_o); end
        tick();
        req_wdata_v_i = 2'b00;
        set_pkt(0, 1'b0, 28'h700);
        req_pkt_v_i = 2'b01;
        #1;
        total++; if (req_pkt_yumi_o !== 2'b01 || dma_pkt_o !== 29'h700) begin bad++; $display("FAIL wr_rdpkt got=%b/%h exp=01/700", req_pkt_yumi_o, dma_pkt_o); end
        tick();
        req_pkt_v_i     = 2'b00;
        dma_pkt_yumi_i  = 1'b0;
        set_wdata(0, 64'hDEAD);
        req_wdata_v_i   = 2'b11;
        dma_data_yumi_i = 1'b1;
        for (int b = 0; b < BL; b++) begin
            set_wdata(1, 64'hB0 + 64'(b));
            #1;
            total++; if (dma_data_v_o !== 1'b1 || dma_data_o !== 64'hB0 + 64'(b)) begin bad++; $display("FAIL wr_beat%0d got=%0b/%h exp=1/%h", b, dma_data_v_o, dma_data_o, 64'hB0 + 64'(b)); end
            total++; if (req_wdata_yumi_o !== 2'b10) begin bad++; $display("FAIL wr_beat%0d_yumi got=%b exp=10", b, req_wdata_yumi_o); end
            tick();
        end
        #1;
        total++; if (dma_data_v_o !== 1'b0 || req_wdata_yumi_o !== 2'b00) begin bad++; $display("FAIL wr_after got=%0b/%b exp=0/00", dma_data_v_o, req_wdata_yumi_o); end
        req_wdata_v_i         = 2'b00;
        dma_data_yumi_i       = 1'b0;
        req_rdata_ready_and_i = 2'b11;
        dma_data_v_i          = 1'b1;
        for (int b = 0; b < BL; b++) begin
            dma_data_i = 64'hC0 + 64'(b);
            #1;
            total++; if (req_rdata_v_o !== 2'b01 || req_rdata_o !== 64'hC0 + 64'(b)) begin bad++; $display("FAIL wr_rd%0d got=%b/%h exp=01/%h", b, req_rdata_v_o, req_rdata_o, 64'hC0 + 64'(b)); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_fifo_full();
        do_reset();
        set_pkt(0, 1'b0, 28'h900);
        req_pkt_v_i    = 2'b01;
        dma_pkt_yumi_i = 1'b1;
        for (int p = 0; p < MO; p++) begin
            #1;
            total++; if (req_pkt_yumi_o !== 2'b01) begin bad++; $display("FAIL full_acc%0d got=%b exp=01", p, req_pkt_yumi_o); end
            tick();
        end
        #1;
        total++; if (dma_pkt_v_o !== 1'b0 || req_pkt_yumi_o !== 2'b00) begin bad++; $display("FAIL full_block got=%0b/%b exp=0/00", dma_pkt_v_o, req_pkt_yumi_o); end
        req_rdata_ready_and_i = 2'b01;
        dma_data_v_i          = 1'b1;
        for (int b = 0; b < BL; b++) begin
            dma_data_i = 64'hF0 + 64'(b);
            #1;
            total++; if (req_rdata_v_o !== 2'b01 || dma_pkt_v_o !== 1'b0) begin bad++; $display("FAIL full_beat%0d got=%b/%0b exp=01/0", b, req_rdata_v_o, dma_pkt_v_o); end
            tick();
        end
        dma_data_v_i = 1'b0;
        #1;
        total++; if (dma_pkt_v_o !== 1'b1 || req_pkt_yumi_o !== 2'b01) begin bad++; $display("FAIL full_release got=%0b/%b exp=1/01", dma_pkt_v_o, req_pkt_yumi_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_pkt(0, 1'b0, 28'hA00);
        req_pkt_v_i    = 2'b01;
        dma_pkt_yumi_i = 1'b1;
        tick();
        req_pkt_v_i           = 2'b00;
        dma_pkt_yumi_i        = 1'b0;
        req_rdata_ready_and_i = 2'b01;
        dma_data_v_i          = 1'b1;
        for (int b = 0; b < 3; b++) begin
            dma_data_i = 64'hD0 + 64'(b);
            tick();
        end
        dma_data_i = 64'hD3;
        reset_i    = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        total++; if (req_rdata_v_o !== 2'b00 || dma_data_ready_and_o !== 1'b0) begin bad++; $display("FAIL mrst_rd got=%b/%0b exp=00/0", req_rdata_v_o, dma_data_ready_and_o); end
        total++; if (dma_pkt_v_o !== 1'b0 || req_pkt_yumi_o !== 2'b00 || dma_data_v_o !== 1'b0) begin bad++; $display("FAIL mrst_pkt got=%0b/%b/%0b exp=0/00/0", dma_pkt_v_o, req_pkt_yumi_o, dma_data_v_o); end
        dma_data_v_i = 1'b0;
        set_pkt(0, 1'b0, 28'hB00);
        req_pkt_v_i    = 2'b01;
        dma_pkt_yumi_i = 1'b1;
        #1;
        total++; if (req_pkt_yumi_o !== 2'b01 || dma_pkt_o !== 29'hB00) begin bad++; $display("FAIL mrst_pkt2 got=%b/%h exp=01/b00", req_pkt_yumi_o, dma_pkt_o); end
        tick();
        req_pkt_v_i    = 2'b00;
        dma_pkt_yumi_i = 1'b0;
        dma_data_v_i   = 1'b1;
        for (int b = 0; b < BL; b++) begin
            dma_data_i = 64'hE0 + 64'(b);
            #1;
            total++; if (req_rdata_v_o !== 2'b01 || dma_data_ready_and_o !== 1'b1) begin bad++; $display("FAIL mrst_beat%0d got=%b/%0b exp=01/1", b, req_rdata_v_o, dma_data_ready_and_o); end
            tick();
        end
        #1;
        total++; if (dma_data_ready_and_o !== 1'b0) begin bad++; $display("FAIL mrst_done_ready got=%0b exp=0", dma_data_ready_and_o); end
`ifdef DRAM_DMA_ARB_STATS_EN
        total++; if (stats_o !== {32'd0, 32'd1}) begin bad++; $display("FAIL mrst_stats got=%h exp=%h", stats_o, {32'd0, 32'd1}); end
        total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL mrst_stall got=%0d exp=0", stall_cnt_o); end
`endif
        clear_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset_i = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_hold();
        test_write_steer();
        test_fifo_full();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
